// File: rtl/reg_prof_pkg.sv
// Shared offsets, CTRL layout and types for reg_access_profiler.
// Word offsets are addr[9:2]; bits [7:5] of the word select the register region.
package reg_prof_pkg;

    localparam logic [7:0] RD_BASE    = 8'h00;
    localparam logic [7:0] WR_BASE    = 8'h20;
    localparam logic [7:0] CTRL_OFS   = 8'h40;
    localparam logic [7:0] STATUS_OFS = 8'h41;
    localparam logic [7:0] CYCLES_OFS = 8'h42;
    localparam logic [7:0] LAST_BASE  = 8'h60;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    typedef struct packed {
        logic clr;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/reg_prof_sat_cnt.sv
// Saturating up-counter with synchronous clear; sat_pulse_o marks the increment that reaches all-ones.
module reg_prof_sat_cnt
    import reg_prof_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clk_sys,
    input  logic             rst_sys_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] value_o,
    output logic             sat_pulse_o
);

    localparam logic [Width-1:0] MaxVal = '1;

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MaxVal)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o     = cnt_q;
    assign sat_pulse_o = !clr_i && inc_i && (cnt_q == MaxVal - 1'b1);

endmodule

// File: rtl/reg_access_profiler.sv
// Per-GPR read/write access counters plus a cycle counter, readable over the simple-system bus.
// Optional REG_PROF_LAST_ACCESS_EN adds a per-GPR last-access timestamp at 0x180+4r.
module reg_access_profiler
    import reg_prof_pkg::*;
#(
    parameter int unsigned NumRegs       = 32,
    parameter int unsigned CntWidth      = 32,
    parameter logic        EnableAtReset = 1'b1
) (
    input  logic               clk_sys,
    input  logic               rst_sys_n,
    input  logic [NumRegs-1:0] rd_hit_i,
    input  logic [NumRegs-1:0] wr_hit_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [3:0]         be_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        wdata_i,
    output logic               rvalid_o,
    output logic [31:0]        rdata_o,
    output logic               err_o
);

    logic [7:0] word;
    logic [2:0] region;
    logic [4:0] idx;
    logic       bus_rd, bus_wr, ctrl_wr, clr;
    ctrl_t      wr_ctrl;

    logic                en_q, en_d;
    logic                sat_q, sat_d;
    logic [CntWidth-1:0] cyc_q, cyc_d;
    logic                rvalid_q, rvalid_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [CntWidth-1:0] rd_cnt [1:NumRegs-1];
    logic [CntWidth-1:0] wr_cnt [1:NumRegs-1];
    logic [NumRegs-1:1]  rd_sat, wr_sat;
    logic [31:0]         rd_val;
    logic                mapped;

    assign word    = addr_i[9:2];
    assign region  = word[7:5];
    assign idx     = word[4:0];
    assign bus_rd  = req_i && !we_i;
    assign bus_wr  = req_i && we_i;
    assign wr_ctrl = ctrl_t'(wdata_i[1:0]);
    assign ctrl_wr = bus_wr && (word == CTRL_OFS) && be_i[0];
    // Clear takes effect on the edge that samples the CTRL write, ahead of any hit.
    assign clr     = ctrl_wr && wr_ctrl.clr;

    for (genvar r = 1; r < NumRegs; r++) begin : g_reg
        reg_prof_sat_cnt #(.Width(CntWidth)) u_rd_cnt (
            .clk_sys     (clk_sys),
            .rst_sys_n   (rst_sys_n),
            .inc_i       (en_q && rd_hit_i[r]),
            .clr_i       (clr),
            .value_o     (rd_cnt[r]),
            .sat_pulse_o (rd_sat[r])
        );
        reg_prof_sat_cnt #(.Width(CntWidth)) u_wr_cnt (
            .clk_sys     (clk_sys),
            .rst_sys_n   (rst_sys_n),
            .inc_i       (en_q && wr_hit_i[r]),
            .clr_i       (clr),
            .value_o     (wr_cnt[r]),
            .sat_pulse_o (wr_sat[r])
        );
    end

`ifdef REG_PROF_LAST_ACCESS_EN
    logic [CntWidth-1:0] last_val [1:NumRegs-1];

    for (genvar r = 1; r < NumRegs; r++) begin : g_last
        logic [CntWidth-1:0] last_q, last_d;

        always_comb begin
            last_d = last_q;
            if (clr) begin
                last_d = '0;
            end else if (en_q && (rd_hit_i[r] || wr_hit_i[r])) begin
                last_d = cyc_q;
            end
        end

        always_ff @(posedge clk_sys or negedge rst_sys_n) begin
            if (!rst_sys_n) begin
                last_q <= '0;
            end else begin
                last_q <= last_d;
            end
        end

        assign last_val[r] = last_q;
    end
`endif

    always_comb begin
        rd_val = '0;
        mapped = 1'b0;
        if (region == RD_BASE[7:5]) begin
            mapped = (32'(idx) < NumRegs);
            if (mapped && (idx != 5'd0)) rd_val = 32'(rd_cnt[idx]);
        end else if (region == WR_BASE[7:5]) begin
            mapped = (32'(idx) < NumRegs);
            if (mapped && (idx != 5'd0)) rd_val = 32'(wr_cnt[idx]);
        end else if (region == CTRL_OFS[7:5]) begin
            case (word)
                CTRL_OFS: begin
                    mapped              = 1'b1;
                    rd_val[CTRL_EN_BIT] = en_q;
                end
                STATUS_OFS: begin
                    mapped    = 1'b1;
                    rd_val[0] = sat_q;
                end
                CYCLES_OFS: begin
                    mapped = 1'b1;
                    rd_val = 32'(cyc_q);
                end
                default: mapped = 1'b0;
            endcase
`ifdef REG_PROF_LAST_ACCESS_EN
        end else if (region == LAST_BASE[7:5]) begin
            mapped = (32'(idx) < NumRegs);
            if (mapped && (idx != 5'd0)) rd_val = 32'(last_val[idx]);
`endif
        end
    end

    always_comb begin
        en_d     = ctrl_wr ? wr_ctrl.en : en_q;
        sat_d    = clr ? 1'b0 : (sat_q || (|rd_sat) || (|wr_sat));
        cyc_d    = clr ? '0 : (en_q ? cyc_q + 1'b1 : cyc_q);
        rvalid_d = req_i;
        err_d    = (bus_rd && !mapped) || (bus_wr && (word != CTRL_OFS));
        rdata_d  = (bus_rd && mapped) ? rd_val : 32'd0;
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            en_q     <= EnableAtReset;
            sat_q    <= 1'b0;
            cyc_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            en_q     <= en_d;
            sat_q    <= sat_d;
            cyc_q    <= cyc_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    logic unused_bits;
    assign unused_bits = ^{addr_i[31:10], addr_i[1:0], be_i[3:1], wdata_i[31:2],
                           rd_hit_i[0], wr_hit_i[0]};

endmodule
